// File: rtl/datapath_pkg.sv
// Shared datapath definitions: default widths and depth, and the result entry record.
package datapath_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DEPTH_DEF      = 8;
  localparam int CNT_WIDTH_DEF  = 16;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] data;
  } result_entry_t;

endpackage

// File: rtl/result_buffer_mem.sv
// Entry storage for the result buffer: one synchronous write port, one
// combinational read port, whole array cleared by the asynchronous reset.
module result_buffer_mem
  import datapath_pkg::*;
#(
  parameter int WIDTH = ADDR_WIDTH_DEF + DATA_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/datapath_result_buffer.sv
// Show-ahead result FIFO behind the datapath: drops (and counts) results when
// full because the datapath cannot be stalled, and XORs every accepted word.
module datapath_result_buffer
  import datapath_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [ADDR_WIDTH-1:0]   out_addr,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  output logic [CNT_WIDTH-1:0]    drop_count,
  output logic [DATA_WIDTH-1:0]   checksum
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int EW    = ADDR_WIDTH + DATA_WIDTH;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic             push, pop, drop;
  logic [EW-1:0]    rd_entry;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign out_valid = ~empty;
  assign count     = count_q;

  // Flush overrides both sides; a pop frees a slot so a push while full is legal.
  assign pop  = out_valid & out_ready & ~flush;
  assign push = in_valid & ~flush & (~full | pop);
  assign drop = in_valid & full & ~pop & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Integrity and drop bookkeeping survive a flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum   <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) checksum <= checksum ^ in_data;
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc(drop_count);
      end
    end
  end

  result_buffer_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data ({in_addr, in_data}),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry)
  );

  assign out_addr = rd_entry[EW-1:DATA_WIDTH];
  assign out_data = rd_entry[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_datapath_result_buffer.sv
// Self-checking bench for datapath_result_buffer: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_datapath_result_buffer;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int DEPTH = 8;
  localparam int CNTW = 16;

  logic          clk, rst_n;
  logic          in_valid, flush, out_ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_addr;
  logic          out_valid, full, empty, overflow;
  logic [DW-1:0] out_data, checksum;
  logic [AW-1:0] out_addr;
  logic [3:0]    count;
  logic [CNTW-1:0] drop_count;

  datapath_result_buffer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_addr(in_addr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .drop_count(drop_count), .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a plain queue of entries plus bookkeeping scalars.
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t          q[$];
  int            m_drop;
  bit            m_ovf;
  logic [DW-1:0] m_csum;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_drop = 0;
    m_ovf  = 1'b0;
    m_csum = '0;
  endtask

  task automatic check_model();
    chk("m_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("m_data", 64'(out_data), 64'(q[0].d));
      chk("m_addr", 64'(out_addr), 64'(q[0].a));
    end
    chk("m_count", 64'(count), 64'(q.size()));
    chk("m_full", 64'(full), 64'(q.size() == DEPTH));
    chk("m_empty", 64'(empty), 64'(q.size() == 0));
    chk("m_ovf", 64'(overflow), 64'(m_ovf));
    chk("m_drop", 64'(drop_count), 64'(m_drop));
    chk("m_csum", 64'(checksum), 64'(m_csum));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare after it.
  task automatic cycle(input bit iv, input logic [DW-1:0] d, input logic [AW-1:0] a,
                       input bit fl, input bit rdy);
    int sz;
    bit p_pop, p_push, p_drop;
    in_valid = iv; in_data = d; in_addr = a; flush = fl; out_ready = rdy;
    @(posedge clk);
    sz     = q.size();
    p_pop  = (sz > 0) && rdy && !fl;
    p_push = iv && !fl && ((sz < DEPTH) || p_pop);
    p_drop = iv && !fl && (sz == DEPTH) && !p_pop;
    if (fl) q.delete();
    else begin
      if (p_pop)  void'(q.pop_front());
      if (p_push) q.push_back('{a: a, d: d});
    end
    if (p_push) m_csum ^= d;
    if (p_drop) begin
      m_ovf = 1'b1;
      if (m_drop < 65535) m_drop++;
    end
    #1;
    check_model();
  endtask

  task automatic do_reset();
    in_valid = 0; in_data = '0; in_addr = '0; flush = 0; out_ready = 0;
    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    bit iv; logic [DW-1:0] d; logic [AW-1:0] a; bit fl; bit rdy;
    bit ev; logic [DW-1:0] ed; logic [AW-1:0] ea; int ec; logic [DW-1:0] ecs;
  } vec_t;
  vec_t tbl[4];

  initial begin
    logic [DW-1:0] exp_cs;
    tbl[0] = '{1'b1, 32'h11, 16'd1, 1'b0, 1'b1, 1'b1, 32'h11, 16'd1, 1, 32'h11};
    tbl[1] = '{1'b1, 32'h22, 16'd2, 1'b0, 1'b1, 1'b1, 32'h22, 16'd2, 1, 32'h33};
    tbl[2] = '{1'b1, 32'h33, 16'd3, 1'b0, 1'b1, 1'b1, 32'h33, 16'd3, 1, 32'h00};
    tbl[3] = '{1'b0, 32'h0,  16'd0, 1'b0, 1'b1, 1'b0, 32'h0,  16'd0, 0, 32'h00};

    // Reset state, sampled while reset is held.
    in_valid = 0; in_data = '0; in_addr = '0; flush = 0; out_ready = 0;
    rst_n = 1'b0;
    model_clear();
    #12;
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_empty", 64'(empty), 1);
    chk("rst_full", 64'(full), 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_data", 64'(out_data), 0);
    chk("rst_addr", 64'(out_addr), 0);
    chk("rst_csum", 64'(checksum), 0);
    chk("rst_drop", 64'(drop_count), 0);
    chk("rst_ovf", 64'(overflow), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic flow from the vector table.
    for (int i = 0; i < 4; i++) begin
      cycle(tbl[i].iv, tbl[i].d, tbl[i].a, tbl[i].fl, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), 64'(out_data), 64'(tbl[i].ed));
        chk($sformatf("tbl%0d_addr", i), 64'(out_addr), 64'(tbl[i].ea));
      end
      chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].ec));
      chk($sformatf("tbl%0d_csum", i), 64'(checksum), 64'(tbl[i].ecs));
    end

    // Fill and stall: 10 pushes into 8 slots.
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      cycle(1, DW'(i), AW'(i), 0, 0);
      if (i == 7) chk("fill_notfull7", 64'(full), 0);
      if (i == 8) chk("fill_full8", 64'(full), 1);
    end
    chk("fill_drop", 64'(drop_count), 2);
    chk("fill_ovf", 64'(overflow), 1);
    chk("fill_csum", 64'(checksum), 64'h08);
    // Held output while stalled.
    cycle(0, '0, '0, 0, 0);
    chk("stall_hold", 64'(out_data), 64'h1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_%0d", i), 64'(out_data), 64'(i));
      cycle(0, '0, '0, 0, 1);
    end
    chk("drain_empty", 64'(empty), 1);

    // Full with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, DW'(32'hC0 + i), AW'(i), 0, 0);
    cycle(1, 32'h55, 16'h55, 0, 1);
    chk("pp_count", 64'(count), 8);
    chk("pp_drop", 64'(drop_count), 0);
    chk("pp_ovf", 64'(overflow), 0);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) chk("pp_last", 64'(out_data), 64'h55);
      cycle(0, '0, '0, 0, 1);
    end

    // Flush priority over push and pop.
    do_reset();
    for (int i = 1; i <= 3; i++) cycle(1, DW'(32'hA0 + i), AW'(i), 0, 0);
    cycle(1, 32'h77, 16'h7, 1, 1);
    chk("fl_count", 64'(count), 0);
    chk("fl_empty", 64'(empty), 1);
    chk("fl_drop", 64'(drop_count), 0);
    chk("fl_csum", 64'(checksum), 64'(32'hA1 ^ 32'hA2 ^ 32'hA3));
    for (int i = 0; i < 3; i++) begin
      cycle(0, '0, '0, 0, 1);
      chk("fl_no77", 64'(out_valid), 0);
    end

    // Pointer wrap with streaming push/pop pairs.
    do_reset();
    exp_cs = '0;
    for (int i = 0; i < 20; i++) begin
      cycle(1, DW'(32'h100 + i), AW'(i), 0, 1);
      exp_cs ^= DW'(32'h100 + i);
      chk($sformatf("wrap_%0d", i), 64'(out_data), 64'(32'h100 + i));
    end
    cycle(0, '0, '0, 0, 1);
    chk("wrap_csum", 64'(checksum), 64'(exp_cs));
    chk("wrap_empty", 64'(empty), 1);

    // Randomized traffic against the model, with varying ready bias.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int rb;
      rb = (i < 130) ? 4 : (i < 260) ? 1 : 2;
      cycle(($urandom % 4) != 0, $urandom, AW'($urandom), ($urandom % 25) == 0,
            ($urandom % rb) == 0);
    end

    // Asynchronous reset mid-burst.
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1, DW'(32'hE0 + i), AW'(i), 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, '0, 0, 1);
    out_ready = 0;
    chk("ar_pre_count", 64'(count), 5);
    chk("ar_pre_ovf", 64'(overflow), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 0);
    chk("ar_count", 64'(count), 0);
    chk("ar_csum", 64'(checksum), 0);
    chk("ar_drop", 64'(drop_count), 0);
    chk("ar_ovf", 64'(overflow), 0);
    chk("ar_data", 64'(out_data), 0);
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(0, '0, '0, 0, 1);
    chk("ar_after_empty", 64'(empty), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/datapath_result_buffer.md
Name: datapath_result_buffer

Overview:
- Downstream stage of the datapath host; consumes its registered result/address/valid stream.
- Buffers results in a small FIFO and re-issues them over a valid/ready handshake to the memory/writeback side.
- The datapath has no backpressure input, so when the buffer is full it drops and counts results instead of stalling.
- Keeps a running XOR checksum of every accepted result for integrity monitoring.

Parameters:
- DATA_WIDTH, 32, result word width; must match the datapath.
- ADDR_WIDTH, 16, address width; must match the datapath.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- CNT_WIDTH, 16, width of the drop counter.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  datapath result valid.
- in_data  in  DATA_WIDTH  datapath result.
- in_addr  in  ADDR_WIDTH  datapath address.
- flush  in  1  synchronous clear of FIFO contents.
- out_valid  out  1  buffered entry available.
- out_ready  in  1  consumer accepts the entry.
- out_data  out  DATA_WIDTH  head entry data.
- out_addr  out  ADDR_WIDTH  head entry address.
- count  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky flag: at least one drop since reset.
- drop_count  out  CNT_WIDTH  number of dropped results; saturating.
- checksum  out  DATA_WIDTH  XOR of all accepted in_data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pointers, count, overflow, drop_count and checksum go to 0.
  - out_valid=0, empty=1, full=0.
  - out_data and out_addr read 0, because memory contents are also cleared.
- Reset mid-operation discards all buffered entries; no partial transfer completes.
- Push: push = in_valid & ~flush & (~full | pop). The entry is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Pop: pop = out_valid & out_ready & ~flush. rd_ptr increments modulo DEPTH.
- Show-ahead (first-word-fall-through) output:
  - out_valid = ~empty.
  - out_data and out_addr are the memory entry at rd_ptr.
  - An entry pushed at edge N is visible at the output after edge N (latency 1).
- Handshake:
  - When out_valid=1 and out_ready=0, out_data and out_addr stay stable.
  - out_valid never drops without a pop, flush or reset.
- Simultaneous push and pop:
  - count is unchanged.
  - This is allowed when full: the slot freed by the pop is reused, and the push is not a drop.
  - When empty, a pop cannot occur because out_valid=0, so only the push takes effect.
- Drop: in_valid & full & ~pop & ~flush.
  - The entry is discarded.
  - overflow is set to 1 and stays set until reset.
  - drop_count increments and saturates at all-ones.
- Checksum: checksum <= checksum ^ in_data on every push. Dropped and flushed inputs do not contribute.
- Flush:
  - Clears rd_ptr, wr_ptr and count next cycle.
  - Flush wins over a same-cycle push or pop: the push is ignored and not counted as a drop, and no pop occurs.
  - Checksum, drop_count and overflow are preserved.
- Pointer wrap: pointers are $clog2(DEPTH) bits wide. The count register disambiguates full from empty.
- Flags are derived from count and have no extra latency.

Decomposition:
- Shared package datapath_pkg holds:
  - default DATA_WIDTH and ADDR_WIDTH constants;
  - DEPTH default;
  - a typedef for the result entry struct {addr, data}.
- One natural sub-module: result_buffer_mem.
  - DEPTH x (ADDR_WIDTH+DATA_WIDTH) register array.
  - One synchronous write port, one combinational read port, asynchronous clear.
- Control (pointers, count, drop/checksum logic) stays in the top level.

Test Plan:
- Basic flow: with out_ready=1, push data 0x11, 0x22, 0x33 with addrs 1, 2, 3 in consecutive cycles -> the same three entries appear in order, each one cycle after its push; count never exceeds 1; checksum = 0x00.
- Fill and stall: out_ready=0, push 10 entries 0x1..0xA -> full=1 after 8 pushes; entries 0x9 and 0xA are dropped; drop_count=2; overflow=1; checksum=0x08; draining returns exactly 0x1..0x8.
- Full with simultaneous push and pop: buffer full, out_ready=1, in_valid=1 with 0x55 -> count stays 8; drop_count unchanged; 0x55 is later popped as the last entry.
- Flush priority: 3 entries buffered, flush=1 together with in_valid=1 (0x77) and out_ready=1 -> next cycle count=0 and empty=1; 0x77 is never output; drop_count and checksum are unchanged.
- Pointer wrap: 20 push/pop pairs of 0x100+i -> all entries are in order with none lost across the pointer wrap; final checksum equals the XOR of 0x100..0x113.
- Async reset mid-burst: assert rst_n=0 with 5 entries and overflow=1, between clock edges -> immediately out_valid=0, count=0, checksum=0, drop_count=0, overflow=0.
